// File: rtl/divmod_restoring_param.sv
// ---------------------------------------------------------------------------
// divmod_restoring_param
//   Multi-cycle unsigned restoring divider that produces both the quotient
//   and the remainder. Operands are latched on the start edge. One quotient
//   bit is produced per RUN cycle, so the fixed latency is DW+2 cycles from
//   start. A zero divisor is flagged and completes directly from LOAD.
//
// Build option:
//   DIVMOD_EARLY_EXIT_EN - when defined, RUN stops as soon as the partial
//                          remainder reaches zero. The remaining quotient
//                          bits are then known to be zero, so the results
//                          are unchanged and only the latency shrinks.
//
// Parameters:
//   DW  dividend / quotient width (DW >= VW >= 1)
//   VW  divisor / remainder width
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset, has priority over start
//   start         one-cycle pulse, operands sampled on the same edge; a start
//                 while busy aborts the running operation
//   dividend      unsigned dividend (DW bits)
//   divisor       unsigned divisor (VW bits), zero allowed
//   quotient      floor(dividend/divisor), all ones on divide-by-zero
//   remainder     dividend mod divisor, dividend[VW-1:0] on divide-by-zero
//   div_by_zero   last completed operation had divisor == 0
//   result_ready  outputs valid: (state == READY) & ~start
//   dbg_state     current FSM state (0 READY, 1 LOAD, 2 RUN)
//
// Handshake: the caller pulses start for one cycle and waits for
// result_ready. result_ready is low from the start cycle until the cycle
// after the final step. quotient/remainder/div_by_zero hold their values
// until the next completion or reset.
// ---------------------------------------------------------------------------
module divmod_restoring_param #(
  parameter int DW = 18,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          result_ready,
  output logic [1:0]    dbg_state
);

  // The aligned divisor needs DW-1 extra bits above the divisor width.
  localparam int DV = DW + VW - 1;
  // The counter must hold DW-1, and cnt+1 must not wrap.
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t        state_q;
  logic [DW-1:0] op_a_q;
  logic [VW-1:0] op_b_q;
  logic [DW-1:0] r_q;
  logic [DV-1:0] d_q;
  logic [DW-1:0] q_acc_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] quotient_q;
  logic [VW-1:0] remainder_q;
  logic          dbz_q;

  // One restoring step: subtract only when the aligned divisor fits.
  logic          take_d;
  logic [DW-1:0] r_d;
  logic [DW-1:0] q_d;

  always_comb begin
    take_d = 1'b0;
    r_d    = r_q;
    q_d    = q_acc_q;
    take_d = (d_q <= DV'(r_q));
    // When take_d is set, d_q <= r_q, so its upper bits are zero and the
    // low DW bits carry the full value.
    r_d    = take_d ? (r_q - d_q[DW-1:0]) : r_q;
    q_d    = DW'({q_acc_q, take_d});
  end

`ifdef DIVMOD_EARLY_EXIT_EN
  // The remaining cnt+1 quotient bits are all zero once r has reached zero.
  logic [DW-1:0] q_early_d;
  always_comb begin
    q_early_d = '0;
    q_early_d = q_acc_q << (cnt_q + CW'(1));
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_READY;
      op_a_q      <= '0;
      op_b_q      <= '0;
      r_q         <= '0;
      d_q         <= '0;
      q_acc_q     <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (start) begin
      // Accepted in any state; a running operation is simply dropped.
      op_a_q  <= dividend;
      op_b_q  <= divisor;
      state_q <= S_LOAD;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (op_b_q == '0) begin
            quotient_q  <= '1;
            remainder_q <= op_a_q[VW-1:0];
            dbz_q       <= 1'b1;
            state_q     <= S_READY;
          end else begin
            r_q     <= op_a_q;
            d_q     <= DV'(op_b_q) << (DW - 1);
            q_acc_q <= '0;
            cnt_q   <= CW'(DW - 1);
            dbz_q   <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
`ifdef DIVMOD_EARLY_EXIT_EN
          if (r_q == '0) begin
            quotient_q  <= q_early_d;
            remainder_q <= '0;
            state_q     <= S_READY;
          end else
`endif
          begin
            r_q     <= r_d;
            d_q     <= d_q >> 1;
            q_acc_q <= q_d;
            cnt_q   <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
              quotient_q  <= q_d;
              remainder_q <= r_d[VW-1:0];
              state_q     <= S_READY;
            end
          end
        end
        default: begin
          state_q <= S_READY;
        end
      endcase
    end
  end

  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign div_by_zero  = dbz_q;
  assign result_ready = (state_q == S_READY) & ~start;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_divmod_restoring_param.sv
// ---------------------------------------------------------------------------
// tb_divmod_restoring_param
//   Self-checking bench for divmod_restoring_param (DW=18, VW=4).
//   Cycle 0 is the cycle in which start is high; inputs are driven 1 time
//   unit after a rising edge and outputs are sampled 4 units after it.
//   Expected values come from plain integer division; latency from the
//   documented timing (and, with DIVMOD_EARLY_EXIT_EN, from the first
//   step at which the running remainder a mod (b*2^i) becomes zero).
// ---------------------------------------------------------------------------
module tb_divmod_restoring_param;

  localparam int DW = 18;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          result_ready;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad = 0;

  divmod_restoring_param #(.DW(DW), .VW(VW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero),
    .result_ready (result_ready),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] model_q(input longint a, input longint b);
    if (b == 0) return DW'((64'd1 << DW) - 1);
    return DW'(a / b);
  endfunction

  function automatic logic [VW-1:0] model_r(input longint a, input longint b);
    if (b == 0) return VW'(a % (64'd1 << VW));
    return VW'(a % b);
  endfunction

  // Cycle index (from the start cycle) in which result_ready first rises.
  function automatic int model_lat(input longint a, input longint b);
    if (b == 0) return 2;
`ifdef DIVMOD_EARLY_EXIT_EN
    if (a == 0) return 3;
    // At the start of RUN step j the remainder equals a mod (b * 2^(DW-j)).
    for (int j = 1; j < DW; j++) begin
      if ((a % (b << (DW - j))) == 0) return 3 + j;
    end
`endif
    return DW + 2;
  endfunction

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts one division in a fresh cycle and checks result and latency.
  task automatic run_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er,
                         input logic ed, input string tag);
    int cyc;
    bit seen;
    next_cycle();
    start = 1'b1;
    dividend = a;
    divisor = b;
    #3;
    check_eq({tag, ".ready_c0"}, result_ready, 1'b0);
    cyc = 0;
    seen = 0;
    while (cyc < 100 && !seen) begin
      next_cycle();
      start = 1'b0;
      dividend = DW'($urandom);
      divisor = VW'($urandom);
      cyc++;
      #3;
      if (result_ready) seen = 1;
    end
    check_eq({tag, ".lat"}, cyc, model_lat(a, b));
    check_eq({tag, ".q"}, quotient, eq);
    check_eq({tag, ".r"}, remainder, er);
    check_eq({tag, ".dbz"}, div_by_zero, ed);
  endtask

  task automatic run_model(input logic [DW-1:0] a, input logic [VW-1:0] b, input string tag);
    run_div(a, b, model_q(a, b), model_r(a, b), (b == 0), tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    bit low_ok;
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;

    // reset
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #3;
    check_eq("rst.q", quotient, 0);
    check_eq("rst.r", remainder, 0);
    check_eq("rst.dbz", div_by_zero, 0);
    check_eq("rst.ready", result_ready, 1);

    // directed
    run_div(18'd200000, 4'd7, 18'd28571, 4'd3, 1'b0, "d200000_7");
    run_div(18'd262143, 4'd1, 18'd262143, 4'd0, 1'b0, "dmax_1");
    run_div(18'd5, 4'd9, 18'd0, 4'd5, 1'b0, "d5_9");
    run_div(18'd1234, 4'd0, 18'h3FFFF, 4'd2, 1'b1, "d1234_0");
    run_div(18'd10, 4'd3, 18'd3, 4'd1, 1'b0, "d10_3");
    run_div(18'd0, 4'd5, 18'd0, 4'd0, 1'b0, "d0_5");
    run_div(18'd96, 4'd3, 18'd32, 4'd0, 1'b0, "d96_3");
    run_div(18'd262143, 4'd15, 18'd17476, 4'd3, 1'b0, "dmax_15");
    run_div(18'd0, 4'd0, 18'h3FFFF, 4'd0, 1'b1, "d0_0");
    check_eq("fixed_lat_200000_7", model_lat(200000, 7), 20);

    // restart: 100/3 at cycle 0, 100/9 at cycle 5 -> ready at cycle 25
    next_cycle();
    start = 1'b1; dividend = 18'd100; divisor = 4'd3;
    low_ok = 1;
    cyc = 0;
    #3;
    if (result_ready) low_ok = 0;
    while (cyc < 100 && !(cyc > 5 && result_ready)) begin
      next_cycle();
      cyc++;
      start = (cyc == 5);
      if (cyc == 5) begin dividend = 18'd100; divisor = 4'd9; end
      #3;
      if (result_ready && cyc < 25) low_ok = 0;
    end
    check_eq("restart.low", low_ok, 1);
    check_eq("restart.lat", cyc, 25);
    check_eq("restart.q", quotient, 11);
    check_eq("restart.r", remainder, 1);

    // reset in cycle 8 of a running divide
    run_div(18'd10, 4'd3, 18'd3, 4'd1, 1'b0, "pre_rst");
    next_cycle();
    start = 1'b1; dividend = 18'd100; divisor = 4'd7;
    for (int i = 1; i <= 8; i++) begin
      next_cycle();
      start = 1'b0;
      reset = (i == 8);
    end
    #3;
    check_eq("midrun.busy_c8", result_ready, 0);
    next_cycle();
    reset = 1'b0;
    #3;
    check_eq("midrun.q", quotient, 0);
    check_eq("midrun.r", remainder, 0);
    check_eq("midrun.ready", result_ready, 1);

    // reset and start together: reset wins, nothing starts
    run_div(18'd1234, 4'd0, 18'h3FFFF, 4'd2, 1'b1, "pre_rs");
    next_cycle();
    reset = 1'b1; start = 1'b1; dividend = 18'd200000; divisor = 4'd7;
    next_cycle();
    reset = 1'b0; start = 1'b0;
    #3;
    check_eq("rs.ready", result_ready, 1);
    check_eq("rs.dbz", div_by_zero, 0);
    check_eq("rs.q", quotient, 0);
    low_ok = 1;
    repeat (25) begin
      next_cycle();
      #3;
      if (!result_ready || quotient != 0) low_ok = 0;
    end
    check_eq("rs.idle", low_ok, 1);

    // random
    for (int i = 0; i < 60; i++) begin
      ra = DW'($urandom_range(0, (1 << DW) - 1));
      rb = VW'($urandom_range(0, (1 << VW) - 1));
      if (i % 10 == 3) rb = '0;
      if (i % 7 == 2) ra = '1;
      if (i % 11 == 5) ra = DW'($urandom_range(0, 40)) * DW'(rb);
      run_model(ra, rb, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
